// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: raster counters, stage-0 pixel request
// with coordinates, and sync/blank outputs delayed to line up with downstream pixel data.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int COORD_W  = 11
) (
  input  logic               clk,
  input  logic               resetPll_n,
  input  logic               enable,
  output logic               pix_req,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               frame_start,
  output logic [15:0]        frame_cnt,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               blank_n,
  output logic               sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [31:0]   H_ACT_E  = 32'(H_ACTIVE);
  localparam logic [31:0]   V_ACT_E  = 32'(V_ACTIVE);
  localparam logic [31:0]   HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]   HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0]   VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]   VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic sync_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, blank_n: 1'b0, sync_n: 1'b1};

  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic               pix_req_q, pix_req_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d;
  logic [COORD_W-1:0] pix_y_q, pix_y_d;
  logic               frame_start_q, frame_start_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  sync_t              pipe_q [PIPE_LAT+1];
  sync_t              pipe_d [PIPE_LAT+1];

  // Comparisons are done at 32 bits so a sync end equal to TOTAL cannot alias to 0.
  logic [31:0] h_ext, v_ext;
  logic        active, hs_act, vs_act;
  sync_t       sync_dec;

  always_comb begin
    h_ext  = 32'(h_cnt_q);
    v_ext  = 32'(v_cnt_q);
    active = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
    hs_act = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_act = (v_ext >= VS_START) && (v_ext < VS_END);
    sync_dec.hsync   = hs_act ? HS_POL : ~HS_POL;
    sync_dec.vsync   = vs_act ? VS_POL : ~VS_POL;
    sync_dec.blank_n = active;
    sync_dec.sync_n  = ~(hs_act | vs_act);
  end

  // NOTE: every always_comb output gets a hold/default value first so no latch is inferred.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pix_req_d     = pix_req_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    pipe_d        = pipe_q;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      pix_req_d     = active;
      pix_x_d       = active ? COORD_W'(h_cnt_q) : '0;
      pix_y_d       = active ? COORD_W'(v_cnt_q) : '0;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      // Counting on the visible pulse makes the new count appear the following cycle.
      if (frame_start_q) frame_cnt_d = frame_cnt_q + 16'd1;
      pipe_d[0] = sync_dec;
      for (int i = 1; i <= PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge resetPll_n) begin
    if (!resetPll_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_req_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      // NOTE: the delay line is reset too; otherwise the DAC sees random sync until it flushes.
      for (int i = 0; i <= PIPE_LAT; i++) pipe_q[i] <= SYNC_IDLE;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_req_q     <= pix_req_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      pipe_q        <= pipe_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q & enable;
  assign frame_cnt   = frame_cnt_q;
  assign vga_hsync   = pipe_q[PIPE_LAT].hsync;
  assign vga_vsync   = pipe_q[PIPE_LAT].vsync;
  assign blank_n     = pipe_q[PIPE_LAT].blank_n;
  assign sync_n      = pipe_q[PIPE_LAT].sync_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing (PIPE_LAT 2 and 0) and a small
// positive-polarity raster (12 x 7) for whole-frame behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, a_en, b_rst_n, b_en, c_rst_n, c_en;
  logic a_req, a_fs, a_hs, a_vs, a_bn, a_sn;
  logic b_req, b_fs, b_hs, b_vs, b_bn, b_sn;
  logic c_req, c_fs, c_hs, c_vs, c_bn, c_sn;
  logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic [15:0] a_fc, b_fc, c_fc;

  vga_timing_gen dut_a (
    .clk(clk), .resetPll_n(a_rst_n), .enable(a_en), .pix_req(a_req), .pix_x(a_x), .pix_y(a_y),
    .frame_start(a_fs), .frame_cnt(a_fc), .vga_hsync(a_hs), .vga_vsync(a_vs),
    .blank_n(a_bn), .sync_n(a_sn));

  vga_timing_gen #(.PIPE_LAT(0)) dut_b (
    .clk(clk), .resetPll_n(b_rst_n), .enable(b_en), .pix_req(b_req), .pix_x(b_x), .pix_y(b_y),
    .frame_start(b_fs), .frame_cnt(b_fc), .vga_hsync(b_hs), .vga_vsync(b_vs),
    .blank_n(b_bn), .sync_n(b_sn));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1)) dut_c (
    .clk(clk), .resetPll_n(c_rst_n), .enable(c_en), .pix_req(c_req), .pix_x(c_x), .pix_y(c_y),
    .frame_start(c_fs), .frame_cnt(c_fc), .vga_hsync(c_hs), .vga_vsync(c_vs),
    .blank_n(c_bn), .sync_n(c_sn));

  int passed = 0;
  int total  = 0;
  int a_cyc  = 0;
  int c_cyc  = 0;

  // One sample point per cycle, on the falling edge; counts enabled rising edges.
  task automatic tick();
    if (a_en && a_rst_n) a_cyc++;
    if (c_en && c_rst_n) c_cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({a_req, a_fs, a_x, a_y, a_fc} !== 39'd0)
      $display("FAIL reset_a_stage0: got req=%b fs=%b x=%0d y=%0d fc=%0d want all 0", a_req, a_fs, a_x, a_y, a_fc);
      else passed++;
    total++; if ({a_hs, a_vs, a_bn, a_sn} !== 4'b1101)
      $display("FAIL reset_a_sync: got %b want 1101", {a_hs, a_vs, a_bn, a_sn}); else passed++;
    total++; if ({b_req, b_fs, b_x, b_y, b_fc} !== 39'd0)
      $display("FAIL reset_b_stage0: got req=%b fs=%b x=%0d y=%0d fc=%0d want all 0", b_req, b_fs, b_x, b_y, b_fc);
      else passed++;
    total++; if ({b_hs, b_vs, b_bn, b_sn} !== 4'b1101)
      $display("FAIL reset_b_sync: got %b want 1101", {b_hs, b_vs, b_bn, b_sn}); else passed++;
    total++; if ({c_req, c_fs, c_x, c_y, c_fc} !== 39'd0)
      $display("FAIL reset_c_stage0: got req=%b fs=%b x=%0d y=%0d fc=%0d want all 0", c_req, c_fs, c_x, c_y, c_fc);
      else passed++;
    total++; if ({c_hs, c_vs, c_bn, c_sn} !== 4'b0001)
      $display("FAIL reset_c_sync: got %b want 0001", {c_hs, c_vs, c_bn, c_sn}); else passed++;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_cyc = 0;
  endtask

  task automatic test_first_frame();
    tick();
    total++; if ({a_fs, a_req, a_x, a_y, a_fc, a_bn} !== {1'b1, 1'b1, 11'd0, 11'd0, 16'd0, 1'b0})
      $display("FAIL first_cycle: got fs=%b req=%b x=%0d y=%0d fc=%0d bn=%b want 1 1 0 0 0 0",
               a_fs, a_req, a_x, a_y, a_fc, a_bn); else passed++;
    tick();
    total++; if ({a_fs, a_x, a_fc} !== {1'b0, 11'd1, 16'd1})
      $display("FAIL second_cycle: got fs=%b x=%0d fc=%0d want 0 1 1", a_fs, a_x, a_fc); else passed++;
    tick();
    total++; if (a_bn !== 1'b1)
      $display("FAIL blank_latency: got blank_n=%b want 1 on third cycle", a_bn); else passed++;
  endtask

  task automatic test_hsync();
    int fall1 = -1, rise1 = -1, fall2 = -1;
    logic prev = a_hs;
    while (fall2 < 0 && a_cyc < 2500) begin
      tick();
      if (prev && !a_hs) begin
        if (fall1 < 0) fall1 = a_cyc; else fall2 = a_cyc;
      end
      if (!prev && a_hs && fall1 >= 0 && rise1 < 0) rise1 = a_cyc;
      prev = a_hs;
    end
    total++; if (fall1 != 659) $display("FAIL hsync_first_fall: got cycle %0d want 659", fall1); else passed++;
    total++; if (rise1 - fall1 != 96) $display("FAIL hsync_low_width: got %0d want 96", rise1 - fall1); else passed++;
    total++; if (fall2 - fall1 != 800) $display("FAIL hsync_period: got %0d want 800", fall2 - fall1); else passed++;
  endtask

  task automatic test_blank_delay();
    for (int line = 0; line < 3; line++) begin
      int   n = 0, lag = 0;
      logic prev_req = a_req;
      logic prev_bbn = b_bn;
      while (!(!prev_req && a_req) && n < 1000) begin
        prev_req = a_req; prev_bbn = b_bn;
        tick(); n++;
      end
      total++; if ({prev_bbn, b_req, b_bn} !== 3'b011)
        $display("FAIL lat0_line%0d: got prev_bn=%b req=%b bn=%b want 0 1 1", line, prev_bbn, b_req, b_bn);
        else passed++;
      while (!a_bn && lag < 10) begin tick(); lag++; end
      total++; if (lag != 2) $display("FAIL lat2_line%0d: got lag %0d want 2", line, lag); else passed++;
    end
  endtask

  task automatic test_enable_freeze();
    int n = 0, bad = 0;
    logic snap_hs, snap_bn, snap_sn;
    logic [10:0] snap_y;
    while (!(a_req && a_x == 11'd300) && n < 1000) begin tick(); n++; end
    total++; if (!(a_req && a_x == 11'd300))
      $display("FAIL freeze_wait: got x=%0d req=%b want x=300 req=1", a_x, a_req); else passed++;
    snap_hs = a_hs; snap_bn = a_bn; snap_sn = a_sn; snap_y = a_y;
    a_en = 1'b0;
    repeat (37) begin
      tick();
      if (a_x != 11'd300 || !a_req || a_fs || a_y != snap_y || a_hs != snap_hs || a_bn != snap_bn || a_sn != snap_sn)
        bad++;
    end
    total++; if (bad != 0) $display("FAIL freeze_hold: got %0d changed cycles want 0", bad); else passed++;
    a_en = 1'b1;
    tick();
    total++; if ({a_req, a_x, a_y} !== {1'b1, 11'd301, snap_y})
      $display("FAIL resume_x: got req=%b x=%0d y=%0d want 1 301 %0d", a_req, a_x, a_y, snap_y); else passed++;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    while (!(a_req && a_y == 11'd6 && a_x == 11'd0) && n < 3000) begin tick(); n++; end
    total++; if (a_fc !== 16'd1) $display("FAIL pre_reset_fc: got %0d want 1", a_fc); else passed++;
    a_rst_n = 1'b0;
    #1;
    total++; if ({a_req, a_fs, a_x, a_y, a_fc} !== 39'd0)
      $display("FAIL async_reset_stage0: got req=%b fs=%b x=%0d y=%0d fc=%0d want all 0", a_req, a_fs, a_x, a_y, a_fc);
      else passed++;
    total++; if ({a_hs, a_vs, a_bn, a_sn} !== 4'b1101)
      $display("FAIL async_reset_sync: got %b want 1101", {a_hs, a_vs, a_bn, a_sn}); else passed++;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1; a_cyc = 0;
    tick();
    total++; if ({a_fs, a_req, a_x, a_y, a_fc} !== {1'b1, 1'b1, 11'd0, 11'd0, 16'd0})
      $display("FAIL restart_pulse: got fs=%b req=%b x=%0d y=%0d fc=%0d want 1 1 0 0 0", a_fs, a_req, a_x, a_y, a_fc);
      else passed++;
    tick();
    total++; if ({a_fs, a_fc} !== {1'b0, 16'd1})
      $display("FAIL restart_fc: got fs=%b fc=%0d want 0 1", a_fs, a_fc); else passed++;
  endtask

  task automatic test_small_timing();
    int hr1 = -1, hf1 = -1, hr2 = -1, vr1 = -1, vf1 = -1, vr2 = -1;
    int reqs = 0, sn_low = 0, sn_bad = 0, fs_cnt = 0;
    logic [10:0] last_x = '0, last_y = '0;
    logic ph = c_hs, pv = c_vs;
    c_rst_n = 1'b1; c_cyc = 0;
    while (c_cyc < 337) begin
      tick();
      if (c_cyc <= 84 && c_req) begin reqs++; last_x = c_x; last_y = c_y; end
      if (!ph && c_hs) begin if (hr1 < 0) hr1 = c_cyc; else if (hr2 < 0) hr2 = c_cyc; end
      if (ph && !c_hs && hf1 < 0) hf1 = c_cyc;
      if (!pv && c_vs) begin if (vr1 < 0) vr1 = c_cyc; else if (vr2 < 0) vr2 = c_cyc; end
      if (pv && !c_vs && vf1 < 0) vf1 = c_cyc;
      if (c_cyc >= 3 && c_cyc <= 86 && !c_sn) sn_low++;
      if (c_sn != !(c_hs || c_vs)) sn_bad++;
      if (c_fs) fs_cnt++;
      ph = c_hs; pv = c_vs;
    end
    total++; if (reqs != 32) $display("FAIL small_req_count: got %0d want 32", reqs); else passed++;
    total++; if ({last_x, last_y} !== {11'd7, 11'd3})
      $display("FAIL small_last_req: got x=%0d y=%0d want 7 3", last_x, last_y); else passed++;
    total++; if (hr1 != 12) $display("FAIL small_hs_rise: got %0d want 12", hr1); else passed++;
    total++; if (hf1 - hr1 != 2) $display("FAIL small_hs_width: got %0d want 2", hf1 - hr1); else passed++;
    total++; if (hr2 - hr1 != 12) $display("FAIL small_hs_period: got %0d want 12", hr2 - hr1); else passed++;
    total++; if (vr1 != 63) $display("FAIL small_vs_rise: got %0d want 63", vr1); else passed++;
    total++; if (vf1 - vr1 != 12) $display("FAIL small_vs_width: got %0d want 12", vf1 - vr1); else passed++;
    total++; if (vr2 - vr1 != 84) $display("FAIL small_vs_period: got %0d want 84", vr2 - vr1); else passed++;
    total++; if (sn_low != 24) $display("FAIL small_sync_n_low: got %0d want 24", sn_low); else passed++;
    total++; if (sn_bad != 0) $display("FAIL small_sync_n_rule: got %0d bad cycles want 0", sn_bad); else passed++;
    total++; if (fs_cnt != 5) $display("FAIL small_fs_count: got %0d want 5", fs_cnt); else passed++;
    total++; if ({c_fs, c_fc} !== {1'b1, 16'd4})
      $display("FAIL small_fc_at_pulse: got fs=%b fc=%0d want 1 4", c_fs, c_fc); else passed++;
    tick();
    total++; if (c_fc !== 16'd5) $display("FAIL small_fc_after: got %0d want 5", c_fc); else passed++;
  endtask

  task automatic test_small_enable();
    int n = 0, start, fs_dis = 0;
    while (!c_fs && n < 200) begin tick(); n++; end
    total++; if (c_fc !== 16'd5) $display("FAIL small_en_fc_at_pulse: got %0d want 5", c_fc); else passed++;
    start = c_cyc;
    for (int i = 0; i < 200; i++) begin
      c_en = (i < 40 || i >= 45);
      tick();
      if (!c_en && c_fs) fs_dis++;
      if (c_fs) break;
    end
    c_en = 1'b1;
    total++; if (c_cyc - start != 84) $display("FAIL small_en_frame_len: got %0d want 84", c_cyc - start); else passed++;
    total++; if (fs_dis != 0) $display("FAIL small_en_fs_disabled: got %0d want 0", fs_dis); else passed++;
    total++; if (c_fc !== 16'd6) $display("FAIL small_en_fc: got %0d want 6", c_fc); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_hsync();
    test_blank_delay();
    test_enable_freeze();
    test_reset_midframe();
    test_small_timing();
    test_small_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
